// File: rtl/seq_pkg.sv
// Shared sequencing constants and elaboration helpers for shift-register counters.
package seq_pkg;

  localparam int SEQ_JOHNSON = 0;
  localparam int SEQ_RING    = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Johnson starts at all ones, ring at a single set bit in position 0.
  function automatic logic [63:0] seq_reset_val(input int mode, input int n);
    logic [63:0] v;
    if (mode == SEQ_RING) v = 64'd1;
    else if (n >= 64)     v = '1;
    else                  v = (64'd1 << n) - 64'd1;
    return v;
  endfunction

endpackage

// File: rtl/johnson_counter_n_if.sv
// Control/status bundle between a sequencer and a johnson_counter_n instance.
interface johnson_counter_n_if
  import seq_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int IW = clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [IW-1:0]    idx;
  logic             tc;
  logic             illegal;

  modport master (output en, dir, load, d, input q, idx, tc, illegal);
  modport slave  (input en, dir, load, d, output q, idx, tc, illegal);

endinterface

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson or ring state into a binary index and legality flag.
module johnson_decode
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = SEQ_JOHNSON,
  parameter int IW    = clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic             illegal
);

  generate
    if (MODE == SEQ_RING) begin : g_ring
      int ones, pos;
      always_comb begin
        ones = 0;
        pos  = 0;
        for (int i = 0; i < WIDTH; i++) begin
          ones += int'(q[i]);
          if (q[i]) pos = i;
        end
      end
      assign illegal = (ones != 1);
      assign idx     = illegal ? '0 : IW'(pos);
    end else begin : g_johnson
      int ones, flips;
      always_comb begin
        ones  = 0;
        flips = 0;
        for (int i = 0; i < WIDTH; i++) ones += int'(q[i]);
        for (int i = 0; i < WIDTH - 1; i++) flips += int'(q[i] ^ q[i+1]);
      end
      assign illegal = (flips > 1);
      // MSB set: ones on top with k zeros below, idx = k.
      // MSB clear: j ones at the bottom (or none), idx = N + j.
      assign idx = illegal    ? '0 :
                   q[WIDTH-1] ? IW'(WIDTH - ones) :
                                IW'(WIDTH + ones);
    end
  endgenerate

endmodule

// File: rtl/johnson_counter_n.sv
// Width-generic Johnson/ring counter: state register and next-state mux around johnson_decode.
module johnson_counter_n
  import seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODE     = SEQ_JOHNSON,
  parameter bit AUTO_FIX = 1'b1
) (
  input logic                clk,
  input logic                rst,
  johnson_counter_n_if.slave bus
);

  localparam int               IW    = clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(seq_reset_val(MODE, WIDTH));
  localparam logic [IW-1:0]    LAST  = IW'((MODE == SEQ_RING) ? WIDTH - 1 : 2 * WIDTH - 1);

  logic [WIDTH-1:0] q, q_up, q_dn, q_next;
  logic [IW-1:0]    idx;
  logic             illegal;

  johnson_decode #(.WIDTH(WIDTH), .MODE(MODE), .IW(IW)) u_dec (
    .q       (q),
    .idx     (idx),
    .illegal (illegal)
  );

  generate
    if (MODE == SEQ_RING) begin : g_ring
      assign q_up = {q[WIDTH-2:0], q[WIDTH-1]};
      assign q_dn = {q[0], q[WIDTH-1:1]};
    end else begin : g_johnson
      assign q_up = {q[WIDTH-2:0], ~q[WIDTH-1]};
      assign q_dn = {~q[0], q[WIDTH-1:1]};
    end
  endgenerate

  // Load beats recovery, recovery beats counting; illegal states keep shifting when AUTO_FIX is off.
  always_comb begin
    q_next = q;
    if (bus.load)                q_next = bus.d;
    else if (illegal && AUTO_FIX) q_next = RST_Q;
    else if (bus.en)             q_next = bus.dir ? q_up : q_dn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_Q;
    else     q <= q_next;
  end

  assign bus.q       = q;
  assign bus.idx     = idx;
  assign bus.illegal = illegal;
  assign bus.tc      = bus.en & ~illegal & (bus.dir ? (idx == LAST) : (idx == '0));

endmodule

// File: tb/tb_johnson_counter_n.sv
// Bench for johnson_counter_n: directed scenarios plus random stimulus against an index-based model.
module tb_johnson_counter_n;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  johnson_counter_n_if #(.WIDTH(8)) if_a ();
  johnson_counter_n_if #(.WIDTH(8)) if_b ();
  johnson_counter_n_if #(.WIDTH(4)) if_c ();

  johnson_counter_n #(.WIDTH(8), .MODE(SEQ_JOHNSON), .AUTO_FIX(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  johnson_counter_n #(.WIDTH(8), .MODE(SEQ_JOHNSON), .AUTO_FIX(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  johnson_counter_n #(.WIDTH(4), .MODE(SEQ_RING),    .AUTO_FIX(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  int cfg_n    [3] = '{8, 8, 4};
  int cfg_mode [3] = '{0, 0, 1};
  int cfg_fix  [3] = '{1, 0, 1};

  // ---------------- reference model: states by sequence position ----------------
  function automatic int seq_len(input int mode, input int n);
    return (mode == 1) ? n : 2 * n;
  endfunction

  function automatic logic [7:0] mask_of(input int n);
    return 8'((1 << n) - 1);
  endfunction

  function automatic logic [7:0] q_of(input int mode, input int n, input int i);
    if (mode == 1) return 8'(1 << i);
    if (i <= n)    return mask_of(n) & ~8'((1 << i) - 1);
    return 8'((1 << (i - n)) - 1);
  endfunction

  function automatic int idx_of(input int mode, input int n, input logic [7:0] q);
    for (int i = 0; i < seq_len(mode, n); i++)
      if (q_of(mode, n, i) == q) return i;
    return -1;
  endfunction

  function automatic logic [7:0] model_next(input int s, input logic [7:0] q,
                                            input logic en, input logic dir,
                                            input logic ld, input logic [7:0] d);
    int n, m, len, i;
    logic [7:0] msk;
    n = cfg_n[s]; m = cfg_mode[s]; len = seq_len(m, n); msk = mask_of(n);
    i = idx_of(m, n, q);
    if (ld) return d & msk;
    if (i < 0 && cfg_fix[s] != 0) return q_of(m, n, 0);
    if (!en) return q;
    if (i >= 0) return q_of(m, n, dir ? (i + 1) % len : (i + len - 1) % len);
    // illegal and not fixed: raw shift (feedback inverted for Johnson)
    if (dir) return ((q << 1) | (((q >> (n - 1)) & 8'd1) ^ 8'(m == 0))) & msk;
    return ((q >> 1) | ((((q & 8'd1) ^ 8'(m == 0))) << (n - 1))) & msk;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic en, input logic dir, input logic ld, input logic [7:0] d);
    if_a.en = en; if_a.dir = dir; if_a.load = ld; if_a.d = d;
    if_b.en = en; if_b.dir = dir; if_b.load = ld; if_b.d = d;
    if_c.en = en; if_c.dir = dir; if_c.load = ld; if_c.d = d[3:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_dut(input int s, output logic [7:0] q, output int idx,
                          output logic tc, output logic ill);
    case (s)
      0:       begin q = if_a.q; idx = int'(if_a.idx); tc = if_a.tc; ill = if_a.illegal; end
      1:       begin q = if_b.q; idx = int'(if_b.idx); tc = if_b.tc; ill = if_b.illegal; end
      default: begin q = {4'h0, if_c.q}; idx = int'(if_c.idx); tc = if_c.tc; ill = if_c.illegal; end
    endcase
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] q; int idx; logic tc, ill;
    logic [7:0] want [3] = '{8'hFF, 8'hFF, 8'h01};
    do_reset();
    for (int s = 0; s < 3; s++) begin
      read_dut(s, q, idx, tc, ill);
      n_cmp++;
      if (q !== want[s] || idx != 0 || tc !== 1'b0 || ill !== 1'b0) begin
        n_err++;
        $display("FAIL reset dut%0d: q=%h idx=%0d tc=%b ill=%b, want q=%h idx=0 tc=0 ill=0",
                 s, q, idx, tc, ill, want[s]);
      end
    end
  endtask

  task automatic test_johnson_up();
    logic [7:0] seq [16] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80,
                             8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    for (int i = 0; i <= 16; i++) begin
      n_cmp++;
      if (if_a.q !== seq[i % 16] || int'(if_a.idx) != i % 16 || if_a.tc !== (i % 16 == 15)) begin
        n_err++;
        $display("FAIL johnson_up[%0d]: q=%h idx=%0d tc=%b, want q=%h idx=%0d tc=%b",
                 i, if_a.q, if_a.idx, if_a.tc, seq[i % 16], i % 16, (i % 16 == 15));
      end
      step();
    end
  endtask

  task automatic test_down_wrap();
    logic [7:0] wq [3] = '{8'hFF, 8'h7F, 8'h3F};
    int         wi [3] = '{0, 15, 14};
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (if_a.q !== wq[i] || int'(if_a.idx) != wi[i] || if_a.tc !== (i == 0)) begin
        n_err++;
        $display("FAIL down_wrap[%0d]: q=%h idx=%0d tc=%b, want q=%h idx=%0d tc=%b",
                 i, if_a.q, if_a.idx, if_a.tc, wq[i], wi[i], (i == 0));
      end
      if (i < 2) step();
    end
  endtask

  task automatic test_enable_load();
    // continues from Q=3F left by the down test
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (5) begin
      step();
      n_cmp++;
      if (if_a.q !== 8'h3F) begin
        n_err++;
        $display("FAIL hold: q=%h want 3f", if_a.q);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 8'h0F);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if (if_a.q !== 8'h0F || int'(if_a.idx) != 12) begin
      n_err++;
      $display("FAIL load: q=%h idx=%0d want q=0f idx=12", if_a.q, if_a.idx);
    end
    step();
    n_cmp++;
    if (if_a.q !== 8'h1F) begin
      n_err++;
      $display("FAIL dir_up: q=%h want 1f", if_a.q);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    n_cmp++;
    if (if_a.q !== 8'h0F) begin
      n_err++;
      $display("FAIL dir_down: q=%h want 0f", if_a.q);
    end
  endtask

  task automatic test_illegal_fix();
    drive(1'b0, 1'b0, 1'b1, 8'hA5);
    step();
    // DIR=0 with EN=1 would raise TC at IDX 0 if ILLEGAL did not gate it
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if (if_a.q !== 8'hA5 || if_a.illegal !== 1'b1 || int'(if_a.idx) != 0 || if_a.tc !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_flag: q=%h ill=%b idx=%0d tc=%b, want q=a5 ill=1 idx=0 tc=0",
               if_a.q, if_a.illegal, if_a.idx, if_a.tc);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    n_cmp++;
    if (if_a.q !== 8'hFF || if_a.illegal !== 1'b0) begin
      n_err++;
      $display("FAIL auto_fix: q=%h ill=%b, want q=ff ill=0", if_a.q, if_a.illegal);
    end
  endtask

  task automatic test_illegal_nofix();
    drive(1'b1, 1'b1, 1'b1, 8'hA5);
    step();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    n_cmp++;
    if (if_b.q !== 8'hA5 || if_b.illegal !== 1'b1) begin
      n_err++;
      $display("FAIL nofix_load: q=%h ill=%b, want q=a5 ill=1", if_b.q, if_b.illegal);
    end
    step();
    n_cmp++;
    if (if_b.q !== 8'h4A || if_b.illegal !== 1'b1) begin
      n_err++;
      $display("FAIL nofix_shift: q=%h ill=%b, want q=4a ill=1", if_b.q, if_b.illegal);
    end
  endtask

  task automatic test_ring_async();
    logic [3:0] seq [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (if_c.q !== seq[i] || if_c.tc !== (i == 3)) begin
        n_err++;
        $display("FAIL ring_up[%0d]: q=%h tc=%b, want q=%h tc=%b", i, if_c.q, if_c.tc, seq[i], (i == 3));
      end
      if (i < 4) step();
    end
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    step();
    #2;
    n_cmp++;
    if (if_c.q !== 4'h4) begin
      n_err++;
      $display("FAIL ring_pre_rst: q=%h want 4", if_c.q);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (if_c.q !== 4'h1 || if_a.q !== 8'hFF) begin
      n_err++;
      $display("FAIL async_rst: ring q=%h johnson q=%h, want 1 and ff", if_c.q, if_a.q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] mq [3];
    logic [7:0] q, d;
    int         idx, ei, len;
    logic       tc, ill, en, dir, ld, want_tc;
    do_reset();
    for (int s = 0; s < 3; s++) mq[s] = q_of(cfg_mode[s], cfg_n[s], 0);
    repeat (400) begin
      @(negedge clk);
      en  = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       d = 8'($urandom);
        1:       d = q_of(0, 8, $urandom_range(0, 15));
        default: d = {4'($urandom), 4'(1 << $urandom_range(0, 3))};
      endcase
      drive(en, dir, ld, d);
      #1;
      for (int s = 0; s < 3; s++) begin
        read_dut(s, q, idx, tc, ill);
        ei      = idx_of(cfg_mode[s], cfg_n[s], mq[s]);
        len     = seq_len(cfg_mode[s], cfg_n[s]);
        want_tc = en && ei >= 0 && (dir ? ei == len - 1 : ei == 0);
        n_cmp++;
        if (q !== mq[s] || idx != (ei < 0 ? 0 : ei) || ill !== (ei < 0) || tc !== want_tc) begin
          n_err++;
          $display("FAIL random dut%0d: q=%h idx=%0d tc=%b ill=%b, want q=%h idx=%0d tc=%b ill=%b",
                   s, q, idx, tc, ill, mq[s], (ei < 0 ? 0 : ei), want_tc, (ei < 0));
        end
      end
      @(posedge clk);
      for (int s = 0; s < 3; s++) mq[s] = model_next(s, mq[s], en, dir, ld, d);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    test_reset();
    test_johnson_up();
    test_down_wrap();
    test_enable_load();
    test_illegal_fix();
    test_illegal_nofix();
    test_ring_async();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/johnson_counter_n.md
# johnson_counter_n

Parametrised shift-register counter, the successor to the fixed 8-bit Johnson counter. It provides width-generic Johnson (twisted-ring) or ring (one-hot) counting with enable, up/down direction, parallel load and illegal-state detection with optional self-correction. It also gives a binary state index and a terminal-count strobe. It sits in the sequencing/timing layer, driving glitch-free decoded phases for card-deal and display strobes.

## Interface
- WIDTH, 8, register width N; legal range N ≥ 2.
- MODE, 0, 0 = Johnson (2N states); 1 = ring (N states).
- AUTO_FIX, 1, 1 = an illegal state is forced to the reset value on the next edge; 0 = flag only.
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  count enable.
- DIR  in  1  1 = up, 0 = down.
- LOAD  in  1  synchronous parallel load.
- D  in  N  load value, taken verbatim; illegal patterns are allowed.
- Q  out  N  counter state, registered.
- IDX  out  clog2(2N)  binary index of the current state, combinational from Q.
- TC  out  1  terminal-count strobe, combinational.
- ILLEGAL  out  1  current Q is not in the legal sequence, combinational.

## Operation
- **Reset values:**
  - Johnson: Q = all ones.
  - Ring: Q = 0…01.
  - In both modes IDX = 0, ILLEGAL = 0, TC = 0 (TC is gated by EN).
- **Johnson up:** Q ← {Q[N-2:0], ~Q[N-1]}.
  - N=8 sequence: FF→FE→FC→…→80→00→01→03→…→7F→FF.
- **Johnson down:** Q ← {~Q[0], Q[N-1:1]}, the exact reverse of the up sequence.
- **Ring up:** rotate left. **Ring down:** rotate right.
- **Legality:**
  - Johnson: legal when at most one i in 0..N-2 has Q[i] ≠ Q[i+1].
  - Ring: legal when exactly one bit is set.
- **IDX (Johnson):**
  - Q with the low k bits zero and the rest ones (0 ≤ k ≤ N): IDX = k.
  - Q with the low j bits one and the rest zero (1 ≤ j ≤ N-1): IDX = N+j.
- **IDX (ring):** IDX = position of the set bit.
- **IDX when illegal:** IDX = 0.
- **Terminal count:** TC = EN & ~ILLEGAL & (DIR ? IDX == LAST : IDX == 0).
  - LAST = 2N-1 in Johnson mode, N-1 in ring mode.
- **Next-state priority at each rising edge:**
  - LOAD: Q ← D.
  - Otherwise, if ILLEGAL & AUTO_FIX: Q ← reset value. EN and DIR are ignored.
  - Otherwise, if EN: step in direction DIR.
  - Otherwise: hold.
- **Wrap-around:** wraps are natural in both directions, with no stall.
  - Up from IDX LAST → 0.
  - Down from IDX 0 → LAST.
- **AUTO_FIX = 0 with an illegal state:** the counter keeps shifting with the same equations. ILLEGAL tracks Q every cycle.

## Timing
- Q changes only on the rising edge of CLK, or immediately on RESET assertion. The counter resumes on the first rising edge after RESET deasserts.
- Latency from LOAD, EN or DIR to Q is 1 cycle. IDX, TC and ILLEGAL follow Q combinationally in the same cycle.
- A DIR change takes effect on the edge where it is sampled, with no turnaround cycle.
- When LOAD is high, EN and DIR are don't-care for that edge.
- RESET mid-count, including during LOAD, overrides everything asynchronously.
- Worst-case recovery from an illegal state with AUTO_FIX = 1 is exactly 1 edge.

## Structure
- **Shared package `seq_pkg`:**
  - Mode constants `SEQ_JOHNSON` = 0 and `SEQ_RING` = 1.
  - A `clog2` function.
  - A reset-value function of (mode, N).
- **Sub-module `johnson_decode`:** purely combinational decode, Q → IDX and ILLEGAL, for both modes. It is reused by display logic that decodes Q externally.
- The top level holds the state register and next-state mux only.

## Test plan
- **Johnson up:** N=8, MODE 0. Reset, then EN=1, DIR=1 for 16 clocks. Required response:
  - Q steps FF,FE,FC,F8,F0,E0,C0,80,00,01,03,07,0F,1F,3F,7F, then back to FF.
  - IDX counts 0..15.
  - TC is high only in the cycle where Q=7F.
- **Down and wrap:** from reset, DIR=0, EN=1. Required response:
  - Q goes FF→7F→3F.
  - IDX goes 0→15→14.
  - TC is high in the first cycle (IDX 0).
- **Enable, direction and load:**
  - With EN=0 for 5 clocks, Q holds.
  - LOAD=1, D=0F with EN=1: the next Q is 0F, IDX=12.
  - Then toggle DIR on consecutive edges: Q goes 0F→1F→0F.
- **Illegal state, AUTO_FIX = 1:** load D=A5. Required response:
  - That cycle: ILLEGAL=1, IDX=0, TC=0.
  - Next edge: Q=FF and ILLEGAL=0, even with EN=0.
- **Illegal state, AUTO_FIX = 0:** load D=A5 with EN=1. Required response:
  - The next Q is 4A (up-shift with inverted feedback).
  - ILLEGAL stays high.
- **Ring mode and async reset:** N=4, MODE 1, EN=1. Required response:
  - Up: Q goes 1→2→4→8→1; TC is high at Q=8.
  - Assert RESET mid-cycle after 2 steps: Q=1 immediately, without waiting for a clock edge.
